// File: rtl/exe_div_unit.sv
// Iterative RV32M DIV/DIVU/REM/REMU unit: one restoring step per cycle, WIDTH-cycle latency
// (divide-by-zero and signed overflow finish at accept); result held until ready_M, flush kills.
module exe_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       funct3_E,
  input  logic [WIDTH-1:0] src1,
  input  logic [WIDTH-1:0] src2,
  input  logic [4:0]       Rd_E,
  input  logic             flush,
  output logic             valid_E,
  input  logic             ready_M,
  output logic [WIDTH-1:0] result,
  output logic [4:0]       Rd_out,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] dvsr_q, dvsr_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [4:0]       rd_q, rd_d;
  logic             rem_flag_q, rem_flag_d;
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;

  logic             is_signed, a_neg, b_neg, div_zero, ovf, step_ge;
  logic [WIDTH-1:0] a_abs, b_abs, quo_step, rem_step, quo_fix, rem_fix;
  logic [WIDTH:0]   rem_sh, diff;

  assign is_signed = ~funct3_E[0];
  assign a_neg     = is_signed & src1[WIDTH-1];
  assign b_neg     = is_signed & src2[WIDTH-1];
  assign a_abs     = a_neg ? -src1 : src1;
  assign b_abs     = b_neg ? -src2 : src2;
  assign div_zero  = (src2 == '0);
  assign ovf       = is_signed & (src1 == {1'b1, {(WIDTH-1){1'b0}}}) & (src2 == '1);

  // Shifted remainder keeps its carry-out bit so divisors above 2^(WIDTH-1) still compare correctly.
  assign rem_sh   = {rem_q, quo_q[WIDTH-1]};
  assign diff     = rem_sh - {1'b0, dvsr_q};
  assign step_ge  = ~diff[WIDTH];
  assign rem_step = step_ge ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
  assign quo_step = {quo_q[WIDTH-2:0], step_ge};
  assign quo_fix  = neg_quo_q ? -quo_step : quo_step;
  assign rem_fix  = neg_rem_q ? -rem_step : rem_step;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    quo_d      = quo_q;
    rem_d      = rem_q;
    dvsr_d     = dvsr_q;
    result_d   = result_q;
    rd_d       = rd_q;
    rem_flag_d = rem_flag_q;
    neg_quo_d  = neg_quo_q;
    neg_rem_d  = neg_rem_q;
    if (flush) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            rd_d       = Rd_E;
            rem_flag_d = funct3_E[1];
            neg_quo_d  = a_neg ^ b_neg;
            neg_rem_d  = a_neg;
            if (div_zero || ovf) begin
              // Both corner cases resolve without iterating; overflow quotient equals src1.
              if (funct3_E[1]) result_d = div_zero ? src1 : '0;
              else             result_d = div_zero ? '1 : src1;
              state_d = S_DONE;
            end else begin
              quo_d   = a_abs;
              rem_d   = '0;
              dvsr_d  = b_abs;
              cnt_d   = '0;
              state_d = S_CALC;
            end
          end
        end
        S_CALC: begin
          quo_d = quo_step;
          rem_d = rem_step;
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH-1)) begin
            result_d = rem_flag_q ? rem_fix : quo_fix;
            state_d  = S_DONE;
          end
        end
        S_DONE: begin
          if (ready_M) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      quo_q      <= '0;
      rem_q      <= '0;
      dvsr_q     <= '0;
      result_q   <= '0;
      rd_q       <= '0;
      rem_flag_q <= 1'b0;
      neg_quo_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      quo_q      <= quo_d;
      rem_q      <= rem_d;
      dvsr_q     <= dvsr_d;
      result_q   <= result_d;
      rd_q       <= rd_d;
      rem_flag_q <= rem_flag_d;
      neg_quo_q  <= neg_quo_d;
      neg_rem_q  <= neg_rem_d;
    end
  end

  assign in_ready = (state_q == S_IDLE);
  assign busy     = (state_q != S_IDLE);
  assign valid_E  = (state_q == S_DONE);
  assign result   = result_q;
  assign Rd_out   = rd_q;

endmodule

// File: tb/tb_exe_div_unit.sv
// Scoreboard bench for exe_div_unit: random and directed ops checked against a plain-arithmetic model.
module tb_exe_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  funct3_E = 3'b100;
  logic [31:0] src1 = '0;
  logic [31:0] src2 = '0;
  logic [4:0]  Rd_E = '0;
  logic        flush = 1'b0;
  logic        valid_E;
  logic        ready_M = 1'b1;
  logic [31:0] result;
  logic [4:0]  Rd_out;
  logic        busy;

  exe_div_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .funct3_E(funct3_E), .src1(src1), .src2(src2), .Rd_E(Rd_E),
    .flush(flush), .valid_E(valid_E), .ready_M(ready_M),
    .result(result), .Rd_out(Rd_out), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] res;
    logic [4:0]  rd;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic logic [31:0] ref_res(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    int  sa = a;
    int  sb = b;
    logic ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (f3)
      3'b100:  return (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'(sa / sb);
      3'b101:  return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'b110:  return (b == 0) ? a : ovf ? 32'h0 : 32'(sa % sb);
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    if (b == 0) return 0;
    if (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 0;
    return 32;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor: every accepted handoff must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst && valid_E && ready_M && !flush) begin
      exp_t e;
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_result: got %h, expected no result", result);
      end else begin
        e = sb_q.pop_front();
        chk("result", result, e.res);
        chk("rd_out", 32'(Rd_out), 32'(e.rd));
      end
    end
  end

  task automatic start_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input bit push);
    int t = 0;
    while (!in_ready && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    if (!in_ready) chk("in_ready_timeout", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b1; funct3_E = f3; src1 = a; src2 = b; Rd_E = rd;
    if (push) sb_q.push_back('{res: ref_res(f3, a, b), rd: rd});
    @(posedge clk); #1;
    // Upstream keeps presenting a different op while busy; none of it may leak into the result.
    funct3_E = 3'(4 + $urandom_range(0, 3));
    src1 = $urandom;
    src2 = $urandom;
    Rd_E = 5'($urandom);
  endtask

  task automatic wait_valid(input int exp_lat);
    int lat = 0;
    chk("busy_after_accept", 32'(busy), 32'd1);
    while (!valid_E && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    in_valid = 1'b0;
    chk("latency", 32'(lat), 32'(exp_lat));
  endtask

  task automatic handoff();
    @(posedge clk); #1;
    chk("valid_after_handoff", 32'(valid_E), 32'd0);
    chk("in_ready_after_handoff", 32'(in_ready), 32'd1);
  endtask

  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
    start_op(f3, a, b, rd, 1'b1);
    wait_valid(ref_lat(f3, a, b));
    handoff();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int hi;
    rst = 1'b1;
    #2 rst = 1'b0;
    #10;
    chk("rst_valid", 32'(valid_E), 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_rd", 32'(Rd_out), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1 rst = 1'b1;

    run_op(3'b100, 32'hFFFF_FFF9, 32'd2, 5'd3);
    run_op(3'b110, 32'hFFFF_FFF9, 32'd2, 5'd3);
    run_op(3'b101, 32'd100, 32'd7, 5'd5);
    run_op(3'b111, 32'd100, 32'd7, 5'd5);
    run_op(3'b100, 32'h1234, 32'd0, 5'd6);
    run_op(3'b110, 32'h1234, 32'd0, 5'd6);
    run_op(3'b111, 32'hFFFF_FFFF, 32'd0, 5'd7);
    run_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8);
    run_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8);
    run_op(3'b101, 32'hFFFF_FFFF, 32'h8000_0001, 5'd9);
    run_op(3'b111, 32'hFFFF_FFFF, 32'h8000_0001, 5'd9);

    // Backpressure: result held for five cycles, no new op accepted.
    ready_M = 1'b0;
    start_op(3'b101, 32'd1000, 32'd10, 5'd9, 1'b1);
    wait_valid(32);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_valid", 32'(valid_E), 32'd1);
      chk("bp_result", result, 32'd100);
      chk("bp_rd", 32'(Rd_out), 32'd9);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
    end
    ready_M = 1'b1;
    handoff();
    run_op(3'b101, 32'd9, 32'd3, 5'd4);

    // Flush during CALC: op disappears.
    start_op(3'b100, 32'd12345, 32'd77, 5'd12, 1'b0);
    repeat (9) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    in_valid = 1'b0;
    chk("flush_in_ready", 32'(in_ready), 32'd1);
    chk("flush_busy", 32'(busy), 32'd0);
    hi = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (valid_E) hi++;
    end
    chk("flush_no_valid", 32'(hi), 32'd0);

    // Flush coinciding with ready_M in DONE drops the result.
    ready_M = 1'b0;
    start_op(3'b100, 32'd5, 32'd0, 5'd7, 1'b0);
    in_valid = 1'b0;
    chk("special_done_valid", 32'(valid_E), 32'd1);
    flush = 1'b1;
    ready_M = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_done_valid", 32'(valid_E), 32'd0);
    chk("flush_done_in_ready", 32'(in_ready), 32'd1);

    // Flush beats accept while idle.
    in_valid = 1'b1; funct3_E = 3'b101; src1 = 32'd10; src2 = 32'd2; flush = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    chk("flush_beats_accept", 32'(busy), 32'd0);

    // Reset in the middle of CALC.
    start_op(3'b100, 32'd1000, 32'd3, 5'd13, 1'b0);
    repeat (19) @(posedge clk);
    #1 rst = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("midrst_valid", 32'(valid_E), 32'd0);
    chk("midrst_result", result, 32'd0);
    chk("midrst_rd", 32'(Rd_out), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    @(posedge clk); #1 rst = 1'b1;
    run_op(3'b100, 32'hFFFF_FF9C, 32'd7, 5'd11);

    for (int i = 0; i < 24; i++) begin
      logic [2:0]  f3;
      logic [31:0] a, b;
      int          mode;
      f3   = 3'(4 + $urandom_range(0, 3));
      mode = $urandom_range(0, 9);
      a    = $urandom;
      b    = $urandom;
      if (mode == 0) b = 32'd0;
      else if (mode == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      else if (mode == 2) begin a = $urandom_range(0, 200); b = $urandom_range(1, 20); end
      else if (mode == 3) b = 32'($urandom_range(1, 15)) | 32'hFFFF_FFF0;
      run_op(f3, a, b, 5'($urandom));
    end

    repeat (3) @(posedge clk);
    chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
